// File: rtl/usb_rx_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : usb_rx_decoder
//  Description : USB receive bit-level decoder. Performs NRZI decode, SYNC
//                hunt, bit unstuffing, EOP handling and LSB-first byte
//                assembly, and presents bytes on a UTMI-style rx interface.
//                Optional feature macro: USB_RX_ERR_CNT_EN adds a saturating
//                err_count output.
//  Revision    : 1.0  initial release
// ============================================================================
module usb_rx_decoder #(
    parameter int SYNC_ZEROS = 5
`ifdef USB_RX_ERR_CNT_EN
    ,
    parameter int ERR_CNT_W  = 8
`endif
) (
    input  logic       clock_480,
    input  logic       reset,
    input  logic       bit_in,
    input  logic       bit_valid,
    input  logic       se0,
    input  logic       fifo_err,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_active,
    output logic       rx_error
`ifdef USB_RX_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_count
`endif
);

    localparam int             c_ZW       = $clog2(SYNC_ZEROS + 1);
    localparam logic [c_ZW-1:0] c_ZERO_MAX = c_ZW'(SYNC_ZEROS);
    localparam logic [c_ZW-1:0] c_ZONE     = c_ZW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t          r_state,    w_state_nx;
    logic            r_prev,     w_prev_nx;
    logic [c_ZW-1:0] r_zero_cnt, w_zero_cnt_nx;
    logic [2:0]      r_ones_cnt, w_ones_cnt_nx;
    logic [2:0]      r_bit_cnt,  w_bit_cnt_nx;
    logic [7:0]      r_shift,    w_shift_nx;
    logic [7:0]      r_rx_data,  w_rx_data_nx;
    logic            r_rx_valid, w_rx_valid_nx;
    logic            r_rx_active, w_rx_active_nx;
    logic            r_rx_error, w_rx_error_nx;
    logic            w_dec;

    // NRZI: no line transition decodes as 1
    assign w_dec = ~(bit_in ^ r_prev);

    // Next-state and output decode; nothing advances without bit_valid
    always_comb begin
        w_state_nx     = r_state;
        w_prev_nx      = r_prev;
        w_zero_cnt_nx  = r_zero_cnt;
        w_ones_cnt_nx  = r_ones_cnt;
        w_bit_cnt_nx   = r_bit_cnt;
        w_shift_nx     = r_shift;
        w_rx_data_nx   = r_rx_data;
        w_rx_valid_nx  = 1'b0;
        w_rx_active_nx = r_rx_active;
        w_rx_error_nx  = 1'b0;

        if (bit_valid) begin
            w_prev_nx = se0 ? 1'b1 : bit_in;
            case (r_state)
                IDLE, SYNC: begin
                    if (se0) begin
                        w_state_nx    = IDLE;
                        w_zero_cnt_nx = '0;
                    end else if (!w_dec) begin
                        // Saturating zero count tolerates lost leading SYNC bits
                        w_state_nx    = SYNC;
                        w_zero_cnt_nx = (r_zero_cnt == c_ZERO_MAX) ? r_zero_cnt
                                                                   : r_zero_cnt + c_ZONE;
                    end else if (r_zero_cnt == c_ZERO_MAX) begin
                        w_state_nx     = DATA;
                        w_zero_cnt_nx  = '0;
                        w_rx_active_nx = 1'b1;
                        // The terminating SYNC 1 counts toward the stuffing run
                        w_ones_cnt_nx  = 3'd1;
                        w_bit_cnt_nx   = 3'd0;
                    end else begin
                        w_state_nx    = IDLE;
                        w_zero_cnt_nx = '0;
                    end
                end
                DATA: begin
                    if (fifo_err) begin
                        // FIFO fault wins over any same-cycle bit, including byte completion
                        w_rx_error_nx = 1'b1;
                        w_state_nx    = ERR;
                    end else if (se0) begin
                        // Up to one dribble bit is tolerated before EOP
                        w_rx_error_nx  = (r_bit_cnt > 3'd1);
                        w_rx_active_nx = 1'b0;
                        w_state_nx     = IDLE;
                        w_zero_cnt_nx  = '0;
                    end else if (r_ones_cnt == 3'd6) begin
                        if (w_dec) begin
                            w_rx_error_nx = 1'b1;
                            w_state_nx    = ERR;
                        end else begin
                            w_ones_cnt_nx = 3'd0;
                        end
                    end else begin
                        w_shift_nx[r_bit_cnt] = w_dec;
                        w_ones_cnt_nx         = w_dec ? r_ones_cnt + 3'd1 : 3'd0;
                        w_bit_cnt_nx          = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            w_rx_data_nx  = {w_dec, r_shift[6:0]};
                            w_rx_valid_nx = 1'b1;
                        end
                    end
                end
                ERR: begin
                    if (se0) begin
                        w_rx_active_nx = 1'b0;
                        w_state_nx     = IDLE;
                        w_zero_cnt_nx  = '0;
                    end
                end
                default: begin
                    w_state_nx    = IDLE;
                    w_zero_cnt_nx = '0;
                end
            endcase
        end
    end

    // State register; reset drops any packet in flight without flagging an error
    always_ff @(posedge clock_480) begin
        if (reset) begin
            r_state     <= IDLE;
            r_prev      <= 1'b1;
            r_zero_cnt  <= '0;
            r_ones_cnt  <= 3'd0;
            r_bit_cnt   <= 3'd0;
            r_shift     <= 8'h00;
            r_rx_data   <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_rx_active <= 1'b0;
            r_rx_error  <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_prev      <= w_prev_nx;
            r_zero_cnt  <= w_zero_cnt_nx;
            r_ones_cnt  <= w_ones_cnt_nx;
            r_bit_cnt   <= w_bit_cnt_nx;
            r_shift     <= w_shift_nx;
            r_rx_data   <= w_rx_data_nx;
            r_rx_valid  <= w_rx_valid_nx;
            r_rx_active <= w_rx_active_nx;
            r_rx_error  <= w_rx_error_nx;
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign rx_active = r_rx_active;
    assign rx_error  = r_rx_error;

`ifdef USB_RX_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] r_err_count;

    // Saturating count of rx_error pulses, cleared only by reset
    always_ff @(posedge clock_480) begin
        if (reset) begin
            r_err_count <= '0;
        end else if (w_rx_error_nx && (r_err_count != '1)) begin
            r_err_count <= r_err_count + ERR_CNT_W'(1);
        end
    end

    assign err_count = r_err_count;
`endif

endmodule
`default_nettype wire
